// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds FSM encoding, CTI/BTE codes and a constant clog2 helper.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TOERR = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester above last owner,
// wrapping around; returns a one-hot grant (all-zero if no request).
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);

  int best;
  int bestj;
  int d;

  // d is the distance of master j from the slot after last
  always_comb begin
    best  = N;
    bestj = 0;
    d     = 0;
    for (int j = 0; j < N; j++) begin
      d = j - int'(last) - 1;
      if (d < 0) d = d + N;
      if (req[j] && d < best) begin
        best  = d;
        bestj = j;
      end
    end
    gnt = '0;
    for (int j = 0; j < N; j++)
      gnt[j] = (best < N) && (bestj == j);
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, with a
// registered grant, no preemption and a slave-silence watchdog.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  arb_state_e    state, state_d;
  logic [IW-1:0] own, own_d;
  logic [IW-1:0] last, last_d;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  grant, grant_d;
  logic [N-1:0]  pick;
  logic [15:0]   cnt, cnt_d;
  logic          o_cyc, o_stb;
  logic          resp, live, owned, toerr;

  wb_rr_pick #(
    .N (N),
    .IW(IW)
  ) u_pick (
    .req (wbm_cyc_i),
    .last(last),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < N; j++)
      if (pick[j]) pick_idx = IW'(j);
  end

  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int j = 0; j < N; j++) begin
      if (own == IW'(j)) begin
        o_cyc     = wbm_cyc_i[j];
        o_stb     = wbm_stb_i[j];
        wbs_adr_o = wbm_adr_i[32*j +: 32];
        wbs_dat_o = wbm_dat_i[32*j +: 32];
        wbs_sel_o = wbm_sel_i[4*j +: 4];
        wbs_we_o  = wbm_we_i[j];
        wbs_cti_o = wbm_cti_i[3*j +: 3];
        wbs_bte_o = wbm_bte_i[2*j +: 2];
      end
    end
  end

  // reset gates strobes and responses in the reset cycle itself
  assign live  = !wb_rst_i;
  assign owned = live && (state == ST_OWNED);
  assign toerr = live && (state == ST_TOERR);
  assign resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbs_cyc_o = owned & o_cyc;
  assign wbs_stb_o = owned & o_stb;
  assign wbm_dat_o = {N{wbs_dat_i}};
  assign grant_o   = grant;
  assign timeout_o = toerr;

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int j = 0; j < N; j++) begin
      wbm_ack_o[j] = wbs_cyc_o && (own == IW'(j)) && wbs_ack_i;
      wbm_err_o[j] = (wbs_cyc_o && (own == IW'(j)) && wbs_err_i)
                  || (toerr && (own == IW'(j)));
      wbm_rty_o[j] = wbs_cyc_o && (own == IW'(j)) && wbs_rty_i;
    end
  end

  always_comb begin
    state_d = state;
    own_d   = own;
    last_d  = last;
    grant_d = grant;
    cnt_d   = '0;
    unique case (state)
      ST_IDLE: begin
        if (|wbm_cyc_i) begin
          state_d = ST_OWNED;
          own_d   = pick_idx;
          grant_d = pick;
        end
      end
      ST_OWNED: begin
        if (!o_cyc) begin
          state_d = ST_IDLE;
          last_d  = own;
          grant_d = '0;
        end else if (o_stb && !resp) begin
          if (cnt == TO_LAST) state_d = ST_TOERR;
          else cnt_d = cnt + 16'd1;
        end
      end
      ST_TOERR: begin
        if (!o_cyc) begin
          state_d = ST_IDLE;
          last_d  = own;
          grant_d = '0;
        end else begin
          state_d = ST_OWNED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      own   <= '0;
      last  <= LAST_INIT;
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      own   <= own_d;
      last  <= last_d;
      grant <= grant_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-free behavioural model.
module tb_wb_rr_arbiter;
  import wb_rr_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int TO = 8;

  logic              wb_clk_i;
  logic              rst;
  logic [32*N-1:0]   m_adr, m_dat;
  logic [4*N-1:0]    m_sel;
  logic [N-1:0]      m_we, m_cyc, m_stb;
  logic [3*N-1:0]    m_cti;
  logic [2*N-1:0]    m_bte;
  logic [32*N-1:0]   m_dat_o;
  logic [N-1:0]      m_ack, m_err, m_rty;
  logic [31:0]       s_adr, s_dat_o, s_dat_i;
  logic [3:0]        s_sel;
  logic              s_we, s_cyc, s_stb;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic              s_ack, s_err, s_rty;
  logic [N-1:0]      grant;
  logic              tmo;

  int total = 0;
  int bad   = 0;
  bit mon_on = 0;

  int md_own   = -1;
  int md_last  = N - 1;
  int md_stall = 0;
  bit md_err   = 0;

  logic [2:0] ctis [4] = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};

  wb_rr_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT    (TO)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (rst),
    .wbm_adr_i(m_adr),
    .wbm_dat_i(m_dat),
    .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti),
    .wbm_bte_i(m_bte),
    .wbm_dat_o(m_dat_o),
    .wbm_ack_o(m_ack),
    .wbm_err_o(m_err),
    .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr),
    .wbs_dat_o(s_dat_o),
    .wbs_sel_o(s_sel),
    .wbs_we_o (s_we),
    .wbs_cyc_o(s_cyc),
    .wbs_stb_o(s_stb),
    .wbs_cti_o(s_cti),
    .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat_i),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic bit at(logic [N-1:0] v, int i);
    return ((v >> i) & N'(1)) != 0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  // model: one owner at a time, stall count, pending watchdog error
  task automatic model_step();
    bit r;
    r = s_ack | s_err | s_rty;
    if (rst) begin
      md_own = -1; md_err = 0; md_stall = 0; md_last = N - 1;
    end else if (md_err) begin
      md_err = 0;
      md_stall = 0;
      if (!at(m_cyc, md_own)) begin
        md_last = md_own; md_own = -1;
      end
    end else if (md_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (md_last + k) % N;
        if (md_own < 0 && at(m_cyc, m)) md_own = m;
      end
      md_stall = 0;
    end else if (!at(m_cyc, md_own)) begin
      md_last = md_own; md_own = -1; md_stall = 0;
    end else if (at(m_stb, md_own) && !r) begin
      md_stall++;
      if (md_stall == TO) begin
        md_err = 1; md_stall = 0;
      end
    end else begin
      md_stall = 0;
    end
  endtask

  always @(posedge wb_clk_i) model_step();

  task automatic compare();
    logic [N-1:0] eg, ea, ee, er;
    logic ec, es, et;
    int o;
    o  = (md_own < 0) ? 0 : md_own;
    eg = '0; ea = '0; ee = '0; er = '0;
    ec = !rst && md_own >= 0 && !md_err && at(m_cyc, o);
    es = !rst && md_own >= 0 && !md_err && at(m_stb, o);
    et = !rst && md_err;
    if (md_own >= 0) eg = N'(1) << o;
    if (ec) begin
      ea = N'(s_ack) << o;
      ee = N'(s_err) << o;
      er = N'(s_rty) << o;
    end
    if (et) ee = N'(1) << o;
    chk("grant", grant, eg);
    chk("wbs_cyc", s_cyc, ec);
    chk("wbs_stb", s_stb, es);
    chk("ack", m_ack, ea);
    chk("err", m_err, ee);
    chk("rty", m_rty, er);
    chk("timeout", tmo, et);
    chk("bcast", m_dat_o, {N{s_dat_i}});
    if (ec) begin
      chk("req_adr_dat", {s_adr, s_dat_o},
          {32'(m_adr >> (32*o)), 32'(m_dat >> (32*o))});
      chk("req_ctl", {s_sel, s_we, s_cti, s_bte},
          {4'(m_sel >> (4*o)), 1'(m_we >> o),
           3'(m_cti >> (3*o)), 2'(m_bte >> (2*o))});
    end
  endtask

  always @(negedge wb_clk_i) if (mon_on) compare();

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench stuck");
    $fatal(1, "bench stuck");
  end

  initial begin
    int acks0, acks1, stalls, to_hits;
    bit seen;
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_dat_i = 32'h0; s_ack = 0; s_err = 0; s_rty = 0;
    repeat (3) step();
    mon_on = 1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      chk("reset_idle",
          {grant, s_cyc, s_stb, m_ack, m_err, m_rty, tmo}, '0);
      step();
    end

    // both masters request together: master 0 first, then 1
    m_adr = {32'h2000_0000, 32'h1000_0000};
    m_cyc = 2'b11;
    @(negedge wb_clk_i);
    chk("no_comb_grant", grant, 2'b00);
    step();
    @(negedge wb_clk_i);
    chk("first_grant", grant, 2'b01);
    chk("first_cyc", s_cyc, 1'b1);
    step();
    step();
    m_cyc[0] = 1'b0;
    @(negedge wb_clk_i);
    chk("release_hold", grant, 2'b01);
    step();
    @(negedge wb_clk_i);
    chk("idle_gap", grant, 2'b00);
    step();
    @(negedge wb_clk_i);
    chk("second_grant", grant, 2'b10);
    m_cyc[1] = 1'b0;
    step();
    step();

    // 4-beat incrementing burst from master 0 while master 1 waits
    acks0 = 0; acks1 = 0;
    m_cyc = 2'b11;
    m_stb[0] = 1'b1;
    m_cti[2:0] = CTI_INCR;
    step();
    for (int b = 0; b < 4; b++) begin
      m_cti[2:0] = ctis[b];
      m_adr[31:0] = 32'h1000 + 32'(4*b);
      s_ack = 1'b1;
      @(negedge wb_clk_i);
      if (b == 0) chk("burst_grant", grant, 2'b01);
      acks0 += int'(m_ack[0]);
      acks1 += int'(m_ack[1]);
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
    chk("burst_acks_m0", acks0, 4);
    chk("burst_acks_m1", acks1, 0);
    step();
    @(negedge wb_clk_i);
    chk("burst_idle", grant, 2'b00);
    step();
    @(negedge wb_clk_i);
    chk("after_burst_m1", grant, 2'b10);
    m_cyc[1] = 1'b0;
    step();
    step();

    // silent slave: watchdog fires after TO stalled cycles
    stalls = 0; seen = 0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge wb_clk_i);
      if (tmo) begin
        seen = 1;
        chk("to_stalls", stalls, TO);
        chk("to_err", m_err, 2'b01);
        chk("to_stb_low", s_stb, 1'b0);
        chk("to_cyc_low", s_cyc, 1'b0);
      end else begin
        if (s_stb) stalls++;
        step();
      end
    end
    chk("to_seen", seen, 1'b1);
    step();
    @(negedge wb_clk_i);
    chk("to_single_pulse", tmo, 1'b0);
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    step();

    // ack on the last allowed stalled cycle wins over the watchdog
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    @(negedge wb_clk_i);
    chk("late_grant", grant, 2'b10);
    repeat (7) step();
    s_ack = 1'b1;
    @(negedge wb_clk_i);
    chk("late_ack", m_ack, 2'b10);
    chk("late_no_err", m_err, 2'b00);
    chk("late_no_to", tmo, 1'b0);
    step();
    s_ack = 1'b0; m_stb[1] = 1'b0;
    to_hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      to_hits += int'(tmo);
      step();
    end
    chk("late_to_quiet", to_hits, 0);
    m_cyc[1] = 1'b0;
    step();
    step();

    // reset in the middle of a master 1 burst
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    m_cti[5:3] = CTI_INCR;
    s_ack = 1'b1;
    step();
    step();
    rst = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_no_err", m_err, 2'b00);
    step();
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b00; s_ack = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_grant_clear", grant, 2'b00);
    chk("rst_err_clear", m_err, 2'b00);
    step();
    @(negedge wb_clk_i);
    chk("post_rst_m0", grant, 2'b01);
    m_cyc = '0;
    step();
    step();

    // random traffic, alternating normal and silent-slave phases
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] nc, ns;
      bit silent, keep, sv;
      int r;
      silent = ((c / 250) % 2) == 1;
      rst = ($urandom % 600) == 0;
      nc = '0; ns = '0;
      for (int m = 0; m < N; m++) begin
        if (at(m_cyc, m))
          keep = ($urandom % (silent ? 40 : 8)) != 0;
        else
          keep = ($urandom % 4) == 0;
        sv = keep && (silent || ($urandom % 3) != 0);
        nc = nc | (N'(keep) << m);
        ns = ns | (N'(sv) << m);
      end
      m_cyc = nc;
      m_stb = ns;
      for (int m = 0; m < N; m++) begin
        m_adr = (m_adr << 32) | (32*N)'($urandom);
        m_dat = (m_dat << 32) | (32*N)'($urandom);
      end
      m_sel = (4*N)'($urandom);
      m_we  = N'($urandom);
      m_cti = (3*N)'($urandom);
      m_bte = (2*N)'($urandom);
      r = int'($urandom % 8);
      s_ack = !silent && r < 3;
      s_err = !silent && r == 3;
      s_rty = !silent && r == 4;
      s_dat_i = $urandom;
      step();
    end

    rst = 1'b0;
    m_cyc = '0; m_stb = '0;
    s_ack = 0; s_err = 0; s_rty = 0;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
